// File: rtl/wormhole_router_2d.sv
// wormhole_router_2d
// Single-node wormhole mesh router (1-D or 2-D). Routing is dimension-ordered (X then Y).
// Each output has its own round-robin arbiter. Links use valid/ready_and handshakes.
//
// Optional feature: define WORMHOLE_ROUTER_ROUTE_ERR_EN to add route_err_o. It is a sticky
// flag that is set when a header arriving on W/E/N/S leaves on the same direction (a U-turn).
//
// Ports (direction index P=0 W=1 E=2 N=3 S=4, flit d packed at [d*flit_width_p +: flit_width_p]):
//   clk_i        clock
//   reset_n_i    asynchronous active-low reset
//   my_cord_i    this node's {y,x}
//   v_i/data_i   inbound flits;  ready_and_o  inbound accept (input FIFO not full)
//   v_o/data_o   outbound flits; ready_and_i  downstream accept
//   route_err_o  sticky U-turn flag (only with WORMHOLE_ROUTER_ROUTE_ERR_EN)
//
// Output lock FSM (one per output):
//   state   | meaning
//   lk_idle | free; arbitrates among headers routed here
//   lk_hdr  | owner granted, but its header is still waiting for ready_and_i
//   lk_body | header sent; rem_q payload flits still to forward from owner
module wormhole_router_2d #(
   parameter int flit_width_p = 32,
   parameter int dims_p       = 2,
   parameter int x_width_p    = 4,
   parameter int y_width_p    = 4,
   parameter int len_width_p  = 4,
   localparam int dirs_p       = 2*dims_p + 1,
   localparam int cord_width_p = (dims_p == 2) ? x_width_p + y_width_p : x_width_p
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic [cord_width_p-1:0]        my_cord_i,
   input  logic [dirs_p-1:0]              v_i,
   input  logic [dirs_p*flit_width_p-1:0] data_i,
   output logic [dirs_p-1:0]              ready_and_o,
   output logic [dirs_p-1:0]              v_o,
   output logic [dirs_p*flit_width_p-1:0] data_o,
   input  logic [dirs_p-1:0]              ready_and_i
`ifdef WORMHOLE_ROUTER_ROUTE_ERR_EN
   ,
   output logic                           route_err_o
`endif
);

   localparam int dir_w = $clog2(dirs_p);
   localparam int ext_w = x_width_p + y_width_p;
   localparam logic [len_width_p-1:0] len_one = len_width_p'(1);

   typedef enum logic [1:0] {lk_idle, lk_hdr, lk_body} lock_e;

   logic [flit_width_p-1:0] mem [dirs_p][2];
   logic [1:0]              cnt_q [dirs_p];
   logic                    wr_ptr_q [dirs_p];
   logic                    rd_ptr_q [dirs_p];
   logic [flit_width_p-1:0] head [dirs_p];
   logic [dirs_p-1:0]       nonempty, enq, deq, claimed;
   logic [dir_w-1:0]        route_dir [dirs_p];
   logic [ext_w-1:0]        my_cord_ext;

   lock_e                   state_q [dirs_p], state_n [dirs_p];
   logic [dir_w-1:0]        owner_q [dirs_p], owner_n [dirs_p];
   logic [len_width_p-1:0]  rem_q [dirs_p], rem_n [dirs_p];
   logic [dir_w-1:0]        rr_q [dirs_p], rr_n [dirs_p];
   logic [dir_w-1:0]        src [dirs_p];
   logic [dirs_p-1:0]       xfer, hdr_xfer;

   // input FIFOs: ready depends only on registered occupancy, and is held low during reset
   always_comb begin
      for (int d = 0; d < dirs_p; d++) begin
         head[d]        = mem[d][rd_ptr_q[d]];
         nonempty[d]    = (cnt_q[d] != 2'd0);
         ready_and_o[d] = reset_n_i && (cnt_q[d] != 2'd2);
         enq[d]         = v_i[d] && ready_and_o[d];
      end
   end

   always_ff @(posedge clk_i) begin
      for (int d = 0; d < dirs_p; d++)
         if (enq[d]) mem[d][wr_ptr_q[d]] <= data_i[d*flit_width_p +: flit_width_p];
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int d = 0; d < dirs_p; d++) begin
            cnt_q[d]    <= 2'd0;
            wr_ptr_q[d] <= 1'b0;
            rd_ptr_q[d] <= 1'b0;
         end
      end else begin
         for (int d = 0; d < dirs_p; d++) begin
            if (enq[d]) wr_ptr_q[d] <= ~wr_ptr_q[d];
            if (deq[d]) rd_ptr_q[d] <= ~rd_ptr_q[d];
            cnt_q[d] <= cnt_q[d] + {1'b0, enq[d]} - {1'b0, deq[d]};
         end
      end
   end

   // route of each FIFO head; it is meaningful only while that head is a header
   always_comb begin
      my_cord_ext = ext_w'(my_cord_i);
      for (int d = 0; d < dirs_p; d++) begin
         route_dir[d] = '0;
         if (head[d][x_width_p-1:0] < my_cord_ext[x_width_p-1:0])
            route_dir[d] = dir_w'(1);
         else if (head[d][x_width_p-1:0] > my_cord_ext[x_width_p-1:0])
            route_dir[d] = dir_w'(2);
         else if (dims_p == 2) begin
            if (head[d][x_width_p +: y_width_p] < my_cord_ext[x_width_p +: y_width_p])
               route_dir[d] = dir_w'(3);
            else if (head[d][x_width_p +: y_width_p] > my_cord_ext[x_width_p +: y_width_p])
               route_dir[d] = dir_w'(4);
         end
      end
   end

   // An input owned by an output is mid-packet, so its head is not a header
   always_comb begin
      claimed = '0;
      for (int o = 0; o < dirs_p; o++)
         if (state_q[o] != lk_idle) claimed[owner_q[o]] = 1'b1;
   end

   always_comb begin
      logic                   gnt_v;
      logic [dir_w-1:0]       gnt_idx;
      logic [len_width_p-1:0] hdr_len;
      int                     idx;
      v_o      = '0;
      data_o   = '0;
      xfer     = '0;
      hdr_xfer = '0;
      deq      = '0;
      for (int o = 0; o < dirs_p; o++) begin
         state_n[o] = state_q[o];
         owner_n[o] = owner_q[o];
         rem_n[o]   = rem_q[o];
         rr_n[o]    = rr_q[o];
         gnt_v      = 1'b0;
         gnt_idx    = '0;
         // search begins just after the last grantee
         for (int k = 1; k <= dirs_p; k++) begin
            idx = int'(rr_q[o]) + k;
            if (idx >= dirs_p) idx = idx - dirs_p;
            if (!gnt_v && nonempty[idx] && !claimed[idx] && route_dir[idx] == dir_w'(o)) begin
               gnt_v   = 1'b1;
               gnt_idx = dir_w'(idx);
            end
         end
         if (state_q[o] == lk_idle) begin
            src[o] = gnt_idx;
            v_o[o] = gnt_v;
         end else begin
            src[o] = owner_q[o];
            v_o[o] = nonempty[owner_q[o]];
         end
         if (v_o[o]) data_o[o*flit_width_p +: flit_width_p] = head[src[o]];
         xfer[o]     = v_o[o] && ready_and_i[o];
         hdr_xfer[o] = xfer[o] && (state_q[o] != lk_body);
         if (xfer[o]) deq[src[o]] = 1'b1;
         hdr_len = head[src[o]][cord_width_p +: len_width_p];
         case (state_q[o])
            lk_idle: begin
               if (gnt_v) begin
                  owner_n[o] = gnt_idx;
                  // a grant waiting on backpressure is held so v_o/data_o stay stable
                  if (!ready_and_i[o]) state_n[o] = lk_hdr;
                  else if (hdr_len != '0) begin
                     state_n[o] = lk_body;
                     rem_n[o]   = hdr_len;
                  end
               end
            end
            lk_hdr: begin
               if (xfer[o]) begin
                  state_n[o] = (hdr_len != '0) ? lk_body : lk_idle;
                  rem_n[o]   = hdr_len;
               end
            end
            lk_body: begin
               if (xfer[o]) begin
                  rem_n[o] = rem_q[o] - len_one;
                  if (rem_q[o] == len_one) state_n[o] = lk_idle;
               end
            end
            default: state_n[o] = lk_idle;
         endcase
         if (hdr_xfer[o]) rr_n[o] = src[o];
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int o = 0; o < dirs_p; o++) begin
            state_q[o] <= lk_idle;
            owner_q[o] <= '0;
            rem_q[o]   <= '0;
            rr_q[o]    <= '0;
         end
      end else begin
         for (int o = 0; o < dirs_p; o++) begin
            state_q[o] <= state_n[o];
            owner_q[o] <= owner_n[o];
            rem_q[o]   <= rem_n[o];
            rr_q[o]    <= rr_n[o];
         end
      end
   end

`ifdef WORMHOLE_ROUTER_ROUTE_ERR_EN
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) route_err_o <= 1'b0;
      else begin
         for (int o = 1; o < dirs_p; o++)
            if (hdr_xfer[o] && src[o] == dir_w'(o)) route_err_o <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_wormhole_router_2d.sv
// Scoreboard bench for wormhole_router_2d at node (x=2,y=2), dims_p=2.
module tb_wormhole_router_2d;
   localparam int fw   = 32;
   localparam int dirs = 5;

   logic              clk_i = 1'b0;
   logic              reset_n_i = 1'b1;
   logic [7:0]        my_cord_i = {4'd2, 4'd2};
   logic [dirs-1:0]   v_i = '0;
   logic [dirs*fw-1:0] data_i = '0;
   logic [dirs-1:0]   ready_and_o, v_o;
   logic [dirs*fw-1:0] data_o;
   logic [dirs-1:0]   ready_and_i = '1;
`ifdef WORMHOLE_ROUTER_ROUTE_ERR_EN
   logic              route_err_o;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] inq  [dirs][$];
   logic [31:0] expq [dirs][$];
   int ocount [dirs];
   int cyc = 0;
   int acc_cyc = -1;
   int out_cyc = -1;
   logic watch_lat = 1'b0;

   wormhole_router_2d dut (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .my_cord_i   (my_cord_i),
      .v_i         (v_i),
      .data_i      (data_i),
      .ready_and_o (ready_and_o),
      .v_o         (v_o),
      .data_o      (data_o),
      .ready_and_i (ready_and_i)
`ifdef WORMHOLE_ROUTER_ROUTE_ERR_EN
      ,
      .route_err_o (route_err_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int route(input int dx, input int dy);
      if (dx < 2) return 1;
      if (dx > 2) return 2;
      if (dy < 2) return 3;
      if (dy > 2) return 4;
      return 0;
   endfunction

   function automatic int pending();
      int n = 0;
      for (int d = 0; d < dirs; d++) n += inq[d].size() + expq[d].size();
      return n;
   endfunction

   // queue a packet on input src and the expected flits on its routed output
   task automatic send_pkt(input int src, input int dx, input int dy, input int len, input int tag);
      logic [31:0] f;
      int o;
      o = route(dx, dy);
      f = {20'(tag), 4'(len), 4'(dy), 4'(dx)};
      inq[src].push_back(f);
      expq[o].push_back(f);
      for (int i = 0; i < len; i++) begin
         f = {20'(tag), 12'(i) ^ 12'h5A0};
         inq[src].push_back(f);
         expq[o].push_back(f);
      end
   endtask

   // drive inputs on the falling edge, then predict and score the next rising-edge transfers
   always @(negedge clk_i) begin
      cyc++;
      for (int d = 0; d < dirs; d++) begin
         v_i[d] = (inq[d].size() != 0);
         data_i[d*fw +: fw] = v_i[d] ? inq[d][0] : 32'h0;
      end
      #1;
      for (int o = 0; o < dirs; o++) begin
         if (v_o[o] && ready_and_i[o]) begin
            if (watch_lat && o == 0 && out_cyc < 0) out_cyc = cyc;
            if (expq[o].size() == 0)
               check($sformatf("spurious_out%0d", o), 32'(expq[o].size()), 32'd1);
            else begin
               check($sformatf("out%0d", o), data_o[o*fw +: fw], expq[o].pop_front());
               ocount[o]++;
            end
         end
      end
      for (int d = 0; d < dirs; d++) begin
         if (v_i[d] && ready_and_o[d]) begin
            if (watch_lat && d == 0 && acc_cyc < 0) acc_cyc = cyc;
            void'(inq[d].pop_front());
         end
      end
   end

   task automatic wait_drain(input string tag, input int budget, output int used);
      used = 0;
      while (pending() != 0 && used < budget) begin
         @(negedge clk_i);
         #2;
         used++;
      end
      check(tag, 32'(pending()), 32'd0);
   endtask

   task automatic apply_reset();
      @(negedge clk_i);
      reset_n_i = 1'b0;
      for (int d = 0; d < dirs; d++) begin
         inq[d].delete();
         expq[d].delete();
      end
      repeat (3) @(negedge clk_i);
      reset_n_i = 1'b1;
      #2;
   endtask

   initial begin
      int used;
      int base;
      logic [31:0] held;

      for (int d = 0; d < dirs; d++) ocount[d] = 0;
      #1 reset_n_i = 1'b0;
      #12;
      check("rst_v_o", 32'(v_o), 32'd0);
      check("rst_ready_and_o", 32'(ready_and_o), 32'd0);
      check("rst_data_o", data_o[31:0] | data_o[63:32] | data_o[95:64] | data_o[127:96] | data_o[159:128], 32'd0);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      #2;
      check("post_rst_ready", 32'(ready_and_o), 32'h1F);

      // P -> P loopback, header + 3 payloads, first flit visible one cycle after accept
      @(posedge clk_i); #1;
      base = ocount[0];
      watch_lat = 1'b1;
      send_pkt(0, 2, 2, 3, 16'h100);
      wait_drain("drain_loopback", 40, used);
      watch_lat = 1'b0;
      check("loopback_flits", 32'(ocount[0] - base), 32'd4);
      check("loopback_latency", 32'(out_cyc - acc_cyc), 32'd1);

      // four independent packets, all outputs busy in parallel
      @(posedge clk_i); #1;
      send_pkt(1, 3, 2, 1, 16'h200);
      send_pkt(2, 1, 2, 0, 16'h300);
      send_pkt(3, 2, 3, 2, 16'h400);
      send_pkt(4, 2, 1, 1, 16'h500);
      wait_drain("drain_parallel", 40, used);
      check("parallel_cycles", 32'(used), 32'd4);
      check("parallel_w_out", 32'(ocount[1]), 32'd1);

      // contention on E after reset: RR pointer at P, so order is W,N,S,P
      apply_reset();
      @(posedge clk_i); #1;
      base = ocount[2];
      send_pkt(1, 3, 2, 2, 16'h610);
      send_pkt(3, 3, 2, 2, 16'h630);
      send_pkt(4, 3, 2, 2, 16'h640);
      send_pkt(0, 3, 2, 2, 16'h600);
      wait_drain("drain_contention", 100, used);
      check("contention_flits", 32'(ocount[2] - base), 32'd12);

      // backpressure on E mid-packet
      @(posedge clk_i); #1;
      base = ocount[2];
      send_pkt(1, 3, 2, 6, 16'h700);
      used = 0;
      while (ocount[2] < base + 2 && used < 40) begin
         @(negedge clk_i);
         #2;
         used++;
      end
      check("bp_start", 32'(ocount[2] - base), 32'd2);
      @(negedge clk_i);
      ready_and_i[2] = 1'b0;
      #2;
      held = data_o[2*fw +: fw];
      repeat (10) begin
         @(negedge clk_i);
         #2;
         check("bp_hold_v", 32'(v_o[2]), 32'd1);
         check("bp_hold_data", data_o[2*fw +: fw], held);
      end
      check("bp_ready_drop", 32'(ready_and_o[1]), 32'd0);
      check("bp_in_backlog", 32'(inq[1].size() != 0), 32'd1);
      @(negedge clk_i);
      ready_and_i[2] = 1'b1;
      wait_drain("drain_bp", 60, used);
      check("bp_flits", 32'(ocount[2] - base), 32'd7);

`ifdef WORMHOLE_ROUTER_ROUTE_ERR_EN
      check("err_clear", 32'(route_err_o), 32'd0);
      @(posedge clk_i); #1;
      base = ocount[1];
      send_pkt(1, 1, 2, 1, 16'h800);
      wait_drain("drain_uturn", 40, used);
      check("uturn_flits", 32'(ocount[1] - base), 32'd2);
      repeat (2) @(negedge clk_i);
      check("err_set", 32'(route_err_o), 32'd1);
      repeat (5) @(negedge clk_i);
      check("err_sticky", 32'(route_err_o), 32'd1);
      apply_reset();
      check("err_reset", 32'(route_err_o), 32'd0);
`endif

      repeat (3) @(negedge clk_i);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
